// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid -- elastic pipeline-stage register with a 2-entry skid buffer.
//
// Carries a control field and a data field between pipeline stages over a
// valid/ready handshake. The main entry drives the outputs; the skid entry
// absorbs one extra beat so in_ready can come straight from a register
// without losing throughput. A synchronous flush empties the stage. Control
// bits are cleared together with the main valid bit, so a bubble can never
// cause a downstream register write.
//
// Optional build macro: PIPE_STAGE_STATS_EN adds saturating statistics
// counters (stall_cnt, bubble_cnt, flush_cnt) and the CNT_W parameter.
//
// Ports:
//   clk        in   clock, all state on rising edge
//   reset      in   synchronous reset, active-low
//   in_valid   in   upstream beat present
//   in_ready   out  stage can accept (registered, = !skid valid)
//   in_ctrl    in   upstream control field [CTRL_W]
//   in_data    in   upstream data field [DATA_W]
//   flush      in   synchronous kill of all held beats
//   out_valid  out  output beat present (registered)
//   out_ready  in   downstream accepts
//   out_ctrl   out  control field, 0 whenever out_valid=0
//   out_data   out  data field, holds last value when invalid
//   stall_cnt  out  cycles with out_valid=1, out_ready=0   (stats build)
//   bubble_cnt out  cycles with out_valid=0                (stats build)
//   flush_cnt  out  cycles with flush=1                    (stats build)
module pipe_stage_skid #(
  parameter int CTRL_W = 3,
  parameter int DATA_W = 101
`ifdef PIPE_STAGE_STATS_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  logic              main_vld_q, main_vld_d;
  logic              skid_vld_q, skid_vld_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              accept;
  logic              issue;

  // Skid occupancy alone decides in_ready, so no path exists from out_ready.
  assign in_ready  = ~skid_vld_q;
  assign accept    = in_valid & ~skid_vld_q;
  assign issue     = main_vld_q & out_ready;

  assign out_valid = main_vld_q;
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;

  always_comb begin
    main_vld_d  = main_vld_q;
    skid_vld_d  = skid_vld_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      // Drop every held and incoming beat; data registers keep their values.
      main_vld_d  = 1'b0;
      skid_vld_d  = 1'b0;
      main_ctrl_d = '0;
    end else begin
      unique case ({skid_vld_q, main_vld_q})
        2'b00: begin
          if (accept) begin
            main_vld_d  = 1'b1;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end
        end
        2'b01: begin
          if (accept && issue) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (accept) begin
            skid_vld_d  = 1'b1;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else if (issue) begin
            main_vld_d  = 1'b0;
            main_ctrl_d = '0;
          end
        end
        2'b11: begin
          if (issue) begin
            skid_vld_d  = 1'b0;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
          end
        end
        default: begin
          // Skid valid without main valid cannot be reached; recover to empty.
          main_vld_d  = 1'b0;
          skid_vld_d  = 1'b0;
          main_ctrl_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      main_vld_q  <= 1'b0;
      skid_vld_q  <= 1'b0;
      main_ctrl_q <= '0;
      main_data_q <= '0;
    end else begin
      main_vld_q  <= main_vld_d;
      skid_vld_q  <= skid_vld_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
    end
  end

  // Skid payload is only meaningful while skid valid is set, so it needs no reset.
  always_ff @(posedge clk) begin
    skid_ctrl_q <= skid_ctrl_d;
    skid_data_q <= skid_data_d;
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, bubble_cnt_q, flush_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) return v + 1'b1;
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      stall_cnt_q  <= sat_inc(stall_cnt_q, main_vld_q & ~out_ready);
      bubble_cnt_q <= sat_inc(bubble_cnt_q, ~main_vld_q);
      flush_cnt_q  <= sat_inc(flush_cnt_q, flush);
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised elastic pipeline-stage register, the successor to the fixed MEM/WB register. It carries a control field and a data field between stages using a valid/ready handshake. A 2-entry skid buffer keeps full throughput while registering in_ready. A synchronous flush turns the stage into a bubble, and control bits are forced to zero whenever the output is not valid, so an empty stage can never cause a register write downstream.

Parameters:
CTRL_W, 3, width of control field (e.g. reg_write_en + result_src); forced to 0 on bubble
DATA_W, 101, width of data field (e.g. alu_result, read_data, rd, pc_plus_4); not cleared on bubble
CNT_W, 16, width of statistics counters (used only with PIPE_STAGE_STATS_EN)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous reset, active-low (0 = reset)
in_valid  input  1  upstream beat present
in_ready  output  1  stage can accept; registered, equals NOT skid_valid
in_ctrl  input  CTRL_W  upstream control field
in_data  input  DATA_W  upstream data field
flush  input  1  synchronous kill of all held beats
out_valid  output  1  output beat present (registered)
out_ready  input  1  downstream accepts
out_ctrl  output  CTRL_W  control field; 0 whenever out_valid=0
out_data  output  DATA_W  data field; holds last value when invalid
stall_cnt  output  CNT_W  (PIPE_STAGE_STATS_EN only) cycles with out_valid=1, out_ready=0
bubble_cnt  output  CNT_W  (PIPE_STAGE_STATS_EN only) cycles with out_valid=0
flush_cnt  output  CNT_W  (PIPE_STAGE_STATS_EN only) cycles with flush=1

Behaviour:
- Storage: main entry (drives outputs) plus skid entry; each entry has its own valid bit.
- Handshakes: accept = in_valid && in_ready; issue = out_valid && out_ready.
- Reset (reset=0 at a rising edge): both valid bits = 0, out_ctrl = 0, out_data = 0, in_ready = 1. Counters = 0. Reset overrides flush and all handshakes.
- States by occupancy:
  - EMPTY: main and skid invalid.
  - ONE: main valid, skid invalid.
  - FULL: main valid, skid valid.
- EMPTY: accept -> ONE, beat loaded into main.
- ONE:
  - accept & issue -> ONE, main reloaded with the new beat.
  - accept & !issue -> FULL, beat loaded into skid.
  - !accept & issue -> EMPTY.
  - otherwise hold.
- FULL: in_ready=0.
  - issue -> ONE, skid moves to main.
  - otherwise hold.
- Latency: 1 cycle from accept to out_valid in EMPTY or ONE; 2 cycles when the beat lands in skid. Throughput is 1 beat/cycle with out_ready held high.
- Order: strictly FIFO; no beat is duplicated or dropped except by flush.
- in_ready: registered only. It has no combinational path from out_ready.
- flush=1 at an edge:
  - Next state EMPTY; both valid bits cleared; out_ctrl=0.
  - A beat handshaken in the same cycle is discarded.
  - out_data and skid data hold their values.
  - An issue in the same cycle still counts as consumed by downstream.
- Bubble rule: out_ctrl is driven from a register cleared together with main_valid, not gated combinationally.
- Holding: out_data and out_ctrl stay stable while out_valid=1 && out_ready=0.

Optional Feature:
PIPE_STAGE_STATS_EN
- Defined: stall_cnt, bubble_cnt and flush_cnt exist. Each increments by 1 per qualifying cycle, saturates at all-ones (no wrap), and clears only on reset.
- Undefined: these ports and their counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid=1 -> out_valid=0, out_ctrl=0, out_data=0, in_ready=1; after release, first beat ctrl=3'b101, data=0x1 appears on the next edge.
- Streaming: out_ready=1, send beats data=1..8 back-to-back -> out_data sequence 1..8 on consecutive cycles starting 1 cycle later, in_ready stays 1.
- Backpressure: out_ready=0 while sending data=0xA, 0xB -> state FULL, in_ready=0, out_data=0xA held; raise out_ready -> 0xA then 0xB issued, in_ready returns to 1 the cycle after the first issue.
- Flush: flush=1 in FULL with in_valid=1, in_ctrl=3'b111 -> next cycle out_valid=0, out_ctrl=0, in_ready=1; neither held beat nor the incoming beat ever appears.
- Reset mid-operation: reset=0 in FULL with flush=1 -> EMPTY, out_data=0 (unlike flush, which holds out_data).
- Stats (PIPE_STAGE_STATS_EN, CNT_W=4): 20 cycles with out_valid=1, out_ready=0 -> stall_cnt=15 (saturated); 3 flush cycles -> flush_cnt=3.
